mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
// - Load/store initiator for the multicycle core: accepts one load/store from the core, drives the
//   data-side port (port B) of the sram block, and returns sized/sign-extended load data or an error.
// - Owns the sram port B timing, because sram read data is registered and its slicing is
//   combinational on size/addr. Addr/size/sign are held until load data has been captured.
// PARAMETERS
// - ADDR_WIDTH  18  byte-address bits backed by sram; any accessed byte with addr[31:ADDR_WIDTH]!=0 is out of range
// PORTS
// - clk          in   1   clock, all state on posedge
// - rst          in   1   asynchronous, active-high reset
// - req_valid    in   1   core request valid; core holds all req_* stable until accepted
// - req_ready    out  1   lsu idle; accept = req_valid && req_ready at posedge
// - req_write    in   1   1=store, 0=load
// - req_size     in   2   00=byte, 01=half, 10=word, 11=illegal
// - req_unsigned in   1   0=sign-extend load, 1=zero-extend load (ignored for stores)
// - req_addr     in   32  byte address
// - req_wdata    in   32  store data, LSBs used for byte/half
// - rsp_valid    out  1   one-cycle pulse, response complete; no backpressure
// - rsp_err      out  1   qualified by rsp_valid; misaligned, illegal size or out of range
// - rsp_rdata    out  32  qualified by rsp_valid && !req_write; 0 for stores and errors
// - mem_read     out  1   sram read_B
// - mem_write    out  1   sram write_B
// - mem_sign     out  1   sram sign_B (0=signed, 1=unsigned)
// - mem_size     out  2   sram size_B
// - mem_addr     out  32  sram addr_B
// - mem_wdata    out  32  sram wr_data_B
// - mem_rdata    in   32  sram rd_data_B (valid the cycle after mem_read, while addr/size/sign are held)
// BEHAVIOUR
// - All outputs are registered.
// - Reset (async) values: state=IDLE; req_ready=0; rsp_valid=0; rsp_err=0; rsp_rdata=0; all mem_* = 0.
//   req_ready rises on the first posedge after rst deasserts.
// - States:
//   - IDLE: req_ready=1. On accept: latch the request, drop req_ready, go to ISSUE; on error go to RESP.
//   - ISSUE: mem_read or mem_write=1 for exactly one cycle, with mem_addr/size/sign/wdata from the request.
//     Load -> CAPTURE. Store -> RESP.
//   - CAPTURE: strobes=0, mem_addr/size/sign held unchanged; mem_rdata is registered into rsp_rdata.
//     Then -> RESP.
//   - RESP: rsp_valid=1 for one cycle, then -> IDLE with req_ready=1. mem_* are held until the next ISSUE.
// - Latency counts from the accept edge to the edge that raises rsp_valid:
//   - aligned load: 3 cycles
//   - aligned store: 2 cycles
//   - error: 1 cycle, with no mem strobe
// - Error checks, evaluated at accept:
//   - req_size==11: error.
//   - half with addr[0]=1, or word with addr[1:0]!=0: misaligned (outcome depends on split mode below).
//   - first or last accessed byte out of range: error.
// - Requests arriving while req_ready=0 are ignored; the core must keep them held.
// - Reset during any state: immediate return to IDLE, strobes drop asynchronously, no rsp_valid is produced.
//   Any store in progress may or may not land.
// - mem_read and mem_write are never asserted together.
// CONFIGURATION
// - LSU_MISALIGN_SPLIT_EN undefined: misaligned half/word gives rsp_err=1 after 1 cycle; memory untouched.
// - LSU_MISALIGN_SPLIT_EN defined: misaligned half/word is split into N unsigned byte accesses
//   (N=2 for half, N=4 for word) at addr, addr+1, ... (32-bit wrap). A 2-bit byte counter sequences them.
//   - Loads: per byte, ISSUE then CAPTURE. Bytes are assembled little-endian.
//     A half is sign/zero-extended after the last byte. Latency 2N+1.
//   - Stores: byte k = req_wdata[8k+:8], N back-to-back ISSUE cycles. Latency N+1.
//   - Range is checked on both first and last byte before any access.
//   - Illegal size is still an error.
// TESTING
// - Word store 0xDEADBEEF @0x100, then word load @0x100 -> rsp 2 cycles / 3 cycles after accept; rdata=0xDEADBEEF, err=0.
// - Signed byte load @0x103 (mem 0xDEADBEEF) -> 0xFFFFFFDE. Unsigned -> 0x000000DE. Signed half @0x102 -> 0xFFFFDEAD.
// - Word load @0x101 -> split off: err=1 after 1 cycle, mem_read never high. Split on: 4 byte reads, latency 9.
//   Data is correct across the word boundary.
// - req_size=11, or addr=0x0004_0000 with ADDR_WIDTH=18 -> err=1, no mem strobe, rdata=0.
// - Second req_valid during CAPTURE -> not accepted until the cycle after rsp_valid. Back-to-back requests lose no data.
// - rst asserted in CAPTURE -> mem_* and rsp_valid=0 immediately, req_ready=0. A new load after release completes normally.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store initiator driving sram port B; outputs are the registered decode of the current state.
// Optional LSU_MISALIGN_SPLIT_EN splits misaligned half/word accesses into unsigned byte accesses.
module mem_lsu #(
  parameter int ADDR_WIDTH = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_sign,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic        accept;
  logic        illegal, misalign, oor, req_err, req_split;
  logic [1:0]  nbytes_m1;
  logic [31:0] last_addr;

  logic        lat_write, lat_unsigned, lat_err, lat_split;
  logic [1:0]  lat_size, lat_last;
  logic [31:0] lat_addr, lat_wdata;

  logic        cap;
  logic [1:0]  cap_idx;
  logic [31:0] byte_buf, merged, split_data, load_data, wd_shift;

  assign accept = req_valid && req_ready;

  always_comb begin
    illegal   = (req_size == 2'b11);
    nbytes_m1 = (req_size == 2'b10) ? 2'd3 : (req_size == 2'b01) ? 2'd1 : 2'd0;
    misalign  = ((req_size == 2'b01) && req_addr[0]) ||
                ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    last_addr = req_addr + {30'b0, nbytes_m1};
    oor       = (|(req_addr >> ADDR_WIDTH)) || (|(last_addr >> ADDR_WIDTH));
`ifdef LSU_MISALIGN_SPLIT_EN
    req_split = misalign && !illegal;
    req_err   = illegal || oor;
`else
    req_split = 1'b0;
    req_err   = illegal || oor || misalign;
`endif
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = req_err ? RESP : ISSUE;
          cnt_nxt   = 2'd0;
        end
      end
      ISSUE: begin
        if (!lat_write) begin
          state_nxt = CAPTURE;
        end else if (cnt == lat_last) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      CAPTURE: begin
        if (cnt == lat_last) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt   = cnt + 2'd1;
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The byte arriving now is merged in the same cycle it is captured, so the last one needs no extra edge.
  always_comb begin
    merged = byte_buf;
    merged[{cap_idx, 3'b000} +: 8] = mem_rdata[7:0];
    split_data = merged;
    if (lat_size == 2'b01) begin
      split_data = {{16{merged[15] & ~lat_unsigned}}, merged[15:0]};
    end
    load_data = lat_split ? split_data : mem_rdata;
    wd_shift  = lat_wdata >> {cnt, 3'b000};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= 32'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_sign     <= 1'b0;
      mem_size     <= 2'b00;
      mem_addr     <= 32'b0;
      mem_wdata    <= 32'b0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_err      <= 1'b0;
      lat_split    <= 1'b0;
      lat_size     <= 2'b00;
      lat_last     <= 2'd0;
      lat_addr     <= 32'b0;
      lat_wdata    <= 32'b0;
      cap          <= 1'b0;
      cap_idx      <= 2'd0;
      byte_buf     <= 32'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= (state == IDLE) && !accept;

      if (accept) begin
        lat_write    <= req_write;
        lat_unsigned <= req_unsigned;
        lat_err      <= req_err;
        lat_split    <= req_split;
        lat_size     <= req_size;
        lat_last     <= req_split ? nbytes_m1 : 2'd0;
        lat_addr     <= req_addr;
        lat_wdata    <= req_wdata;
      end

      mem_read  <= (state == ISSUE) && !lat_write;
      mem_write <= (state == ISSUE) && lat_write;
      if (state == ISSUE) begin
        mem_addr <= lat_addr + {30'b0, cnt};
        if (lat_split) begin
          mem_size  <= 2'b00;
          mem_sign  <= 1'b1;
          mem_wdata <= {24'b0, wd_shift[7:0]};
        end else begin
          mem_size  <= lat_size;
          mem_sign  <= lat_unsigned;
          mem_wdata <= lat_wdata;
        end
      end

      cap     <= (state == CAPTURE);
      cap_idx <= cnt;
      if (cap) begin
        byte_buf <= merged;
      end

      rsp_valid <= (state == RESP);
      rsp_err   <= (state == RESP) && lat_err;
      rsp_rdata <= ((state == RESP) && !lat_err && !lat_write) ? load_data : 32'b0;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a behavioural sram port B model (registered read, combinational slice).
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write, mem_sign;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int cmp = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_WIDTH(18)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_sign(mem_sign), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [7:0]  mem [0:4095];
  logic [31:0] rd_q;
  logic [15:0] sh;
  logic [11:0] ma, mw;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        both_seen = 1'b0;

  always @(posedge clk) begin
    ma = mem_addr[11:0];
    mw = {ma[11:2], 2'b00};
    if (mem_read && mem_write) both_seen = 1'b1;
    if (mem_read) begin
      rd_cnt = rd_cnt + 1;
      rd_q <= {mem[mw + 12'd3], mem[mw + 12'd2], mem[mw + 12'd1], mem[mw]};
    end
    if (mem_write) begin
      wr_cnt = wr_cnt + 1;
      mem[ma] <= mem_wdata[7:0];
      if (mem_size != 2'b00) mem[ma + 12'd1] <= mem_wdata[15:8];
      if (mem_size == 2'b10) begin
        mem[ma + 12'd2] <= mem_wdata[23:16];
        mem[ma + 12'd3] <= mem_wdata[31:24];
      end
    end
  end

  always_comb begin
    sh = 16'(rd_q >> {mem_addr[1:0], 3'b000});
    case (mem_size)
      2'b00:   mem_rdata = mem_sign ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   mem_rdata = mem_sign ? {16'b0, sh} : {{16{sh[15]}}, sh};
      default: mem_rdata = rd_q;
    endcase
  end

  // Drives one request and returns edges from accept to rsp_valid (-1 on timeout).
  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] ad, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rd);
    int n;
    lat = -1; err = 1'bx; rd = 32'hx;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = ad; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) begin
        lat = i; err = rsp_err; rd = rsp_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cmp++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", req_ready); end
    cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== 34'b0) begin bad++; $display("FAIL reset_rsp got %b/%b/%h want 0", rsp_valid, rsp_err, rsp_rdata); end
    cmp++; if ({mem_read, mem_write, mem_sign, mem_size, mem_addr, mem_wdata} !== 69'b0) begin bad++; $display("FAIL reset_mem got rd=%b wr=%b addr=%h want all 0", mem_read, mem_write, mem_addr); end
    rst = 1'b0;
    #1;
    cmp++; if (req_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got %b want 0", req_ready); end
    @(negedge clk);
    cmp++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got %b want 1", req_ready); end
  endtask

  task automatic test_store_load();
    int lat; logic err; logic [31:0] rd; int w0;
    w0 = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, lat, err, rd);
    cmp++; if (lat !== 2) begin bad++; $display("FAIL st_lat got %0d want 2", lat); end
    cmp++; if (err !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL st_rsp got err=%b rd=%h want 0/0", err, rd); end
    cmp++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL st_writes got %0d want 1", wr_cnt - w0); end
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, err, rd);
    cmp++; if (lat !== 3) begin bad++; $display("FAIL ld_lat got %0d want 3", lat); end
    cmp++; if (err !== 1'b0 || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_word got err=%b rd=%h want 0/deadbeef", err, rd); end
  endtask

  task automatic test_sub_word();
    int lat; logic err; logic [31:0] rd;
    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, lat, err, rd);
    cmp++; if (rd !== 32'hFFFFFFDE || lat !== 3) begin bad++; $display("FAIL ld_sbyte got %h lat %0d want ffffffde lat 3", rd, lat); end
    do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, lat, err, rd);
    cmp++; if (rd !== 32'h000000DE) begin bad++; $display("FAIL ld_ubyte got %h want 000000de", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, err, rd);
    cmp++; if (rd !== 32'hFFFFDEAD || err !== 1'b0) begin bad++; $display("FAIL ld_shalf got %h err %b want ffffdead 0", rd, err); end
  endtask

  task automatic test_misaligned();
    int lat; logic err; logic [31:0] rd; int r0, w0;
    do_req(1'b1, 2'b10, 1'b0, 32'h104, 32'h11223344, lat, err, rd);
    cmp++; if (lat !== 2 || err !== 1'b0) begin bad++; $display("FAIL st_104 got lat %0d err %b want 2 0", lat, err); end
    r0 = rd_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, lat, err, rd);
`ifdef LSU_MISALIGN_SPLIT_EN
    cmp++; if (lat !== 9 || err !== 1'b0 || rd !== 32'h44DEADBE) begin bad++; $display("FAIL mis_ldw got lat %0d err %b rd %h want 9 0 44deadbe", lat, err, rd); end
    cmp++; if (rd_cnt - r0 !== 4) begin bad++; $display("FAIL mis_ldw_reads got %0d want 4", rd_cnt - r0); end
`else
    cmp++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL mis_ldw got lat %0d err %b rd %h want 1 1 0", lat, err, rd); end
    cmp++; if (rd_cnt - r0 !== 0) begin bad++; $display("FAIL mis_ldw_reads got %0d want 0", rd_cnt - r0); end
`endif
    w0 = wr_cnt;
    do_req(1'b1, 2'b01, 1'b0, 32'h105, 32'h0000A55A, lat, err, rd);
`ifdef LSU_MISALIGN_SPLIT_EN
    cmp++; if (lat !== 3 || err !== 1'b0 || wr_cnt - w0 !== 2) begin bad++; $display("FAIL mis_sth got lat %0d err %b writes %0d want 3 0 2", lat, err, wr_cnt - w0); end
`else
    cmp++; if (lat !== 1 || err !== 1'b1 || wr_cnt - w0 !== 0) begin bad++; $display("FAIL mis_sth got lat %0d err %b writes %0d want 1 1 0", lat, err, wr_cnt - w0); end
`endif
    do_req(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, lat, err, rd);
`ifdef LSU_MISALIGN_SPLIT_EN
    cmp++; if (rd !== 32'h11A55A44) begin bad++; $display("FAIL mis_sth_data got %h want 11a55a44", rd); end
`else
    cmp++; if (rd !== 32'h11223344) begin bad++; $display("FAIL mis_sth_data got %h want 11223344", rd); end
`endif
    do_req(1'b0, 2'b01, 1'b0, 32'h105, 32'h0, lat, err, rd);
`ifdef LSU_MISALIGN_SPLIT_EN
    cmp++; if (lat !== 5 || err !== 1'b0 || rd !== 32'hFFFFA55A) begin bad++; $display("FAIL mis_ldh got lat %0d err %b rd %h want 5 0 ffffa55a", lat, err, rd); end
`else
    cmp++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL mis_ldh got lat %0d err %b rd %h want 1 1 0", lat, err, rd); end
`endif
  endtask

  task automatic test_errors();
    int lat; logic err; logic [31:0] rd; int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, lat, err, rd);
    cmp++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL size11 got lat %0d err %b rd %h want 1 1 0", lat, err, rd); end
    do_req(1'b0, 2'b10, 1'b0, 32'h0004_0000, 32'h0, lat, err, rd);
    cmp++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL oor_first got lat %0d err %b rd %h want 1 1 0", lat, err, rd); end
    do_req(1'b1, 2'b10, 1'b0, 32'h0003_FFFE, 32'h12345678, lat, err, rd);
    cmp++; if (lat !== 1 || err !== 1'b1) begin bad++; $display("FAIL oor_last got lat %0d err %b want 1 1", lat, err); end
    cmp++; if (rd_cnt - r0 !== 0 || wr_cnt - w0 !== 0) begin bad++; $display("FAIL err_strobes got rd %0d wr %0d want 0 0", rd_cnt - r0, wr_cnt - w0); end
    do_req(1'b0, 2'b00, 1'b0, 32'h0003_FFFF, 32'h0, lat, err, rd);
    cmp++; if (lat !== 3 || err !== 1'b0) begin bad++; $display("FAIL top_byte got lat %0d err %b want 3 0", lat, err); end
    do_req(1'b0, 2'b10, 1'b0, 32'h0003_FFFC, 32'h0, lat, err, rd);
    cmp++; if (lat !== 3 || err !== 1'b0) begin bad++; $display("FAIL top_word got lat %0d err %b want 3 0", lat, err); end
  endtask

  task automatic test_back_to_back();
    int r1, rdy, acc, r2, n;
    logic [31:0] d1, d2;
    r1 = -1; rdy = -1; acc = -1; r2 = -1; d1 = 32'hx; d2 = 32'hx; n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h104;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      if (rdy > 0 && acc < 0) begin
        acc = i;
        #1 req_valid = 1'b0;
      end
      @(negedge clk);
      if (rsp_valid) begin
        if (r1 < 0) begin r1 = i; d1 = rsp_rdata; end
        else if (r2 < 0) begin r2 = i; d2 = rsp_rdata; end
      end
      if (req_ready && rdy < 0) rdy = i;
    end
    req_valid = 1'b0;
    cmp++; if (r1 !== 3 || d1 !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_first got cyc %0d rd %h want 3 deadbeef", r1, d1); end
    cmp++; if (rdy !== 4 || acc !== 5) begin bad++; $display("FAIL b2b_ready got ready %0d accept %0d want 4 5", rdy, acc); end
    cmp++; if (r2 !== 8 || d2 !== 32'h00000044) begin bad++; $display("FAIL b2b_second got cyc %0d rd %h want 8 00000044", r2, d2); end
  endtask

  task automatic test_reset_capture();
    int lat; logic err; logic [31:0] rd; int n; logic seen;
    n = 0; seen = 1'b0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmp++; if (mem_read !== 1'b1) begin bad++; $display("FAIL rstcap_pre got mem_read %b want 1", mem_read); end
    rst = 1'b1;
    #1;
    cmp++; if (mem_read !== 1'b0 || mem_addr !== 32'h0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL rstcap_async got rd %b addr %h rsp %b rdy %b want 0 0 0 0", mem_read, mem_addr, rsp_valid, req_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    cmp++; if (seen !== 1'b0) begin bad++; $display("FAIL rstcap_rsp got rsp_valid seen %b want 0", seen); end
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, err, rd);
    cmp++; if (lat !== 3 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rstcap_after got lat %0d err %b rd %h want 3 0 deadbeef", lat, err, rd); end
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rst = 1'b1;
    test_reset();
    test_store_load();
    test_sub_word();
    test_misaligned();
    test_errors();
    test_back_to_back();
    test_reset_capture();
    cmp++; if (both_seen !== 1'b0) begin bad++; $display("FAIL strobe_excl got both %b want 0", both_seen); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
